// File: rtl/ram_arb_pkg.sv
//==============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and helpers for the buffer-RAM port arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [0:0] {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int c_default_lock_max = 16;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
//==============================================================================
// Module      : rr_pick
// Description : One-hot priority pick starting at a rotating start index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_pick
    import ram_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;

    // Requests at or above start win first; otherwise wrap to the lowest set bit.
    assign w_mask = ~((N'(1) << start) - N'(1));
    assign w_hi   = req & w_mask;
    assign grant  = (|w_hi) ? (w_hi & (~w_hi + N'(1))) : (req & (~req + N'(1)));

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
//==============================================================================
// Module      : ram_port_arbiter
// Description : Arbitrates N_REQ requesters onto one single-port buffer RAM,
//               with bounded burst lock and read-data return routing.
//               ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef ADDR_SIZE
`define ADDR_SIZE 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int AW       = `ADDR_SIZE,
    parameter int DW       = `DATA_WIDTH,
    parameter int LOCK_MAX = c_default_lock_max
) (
    input  logic                clka,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_we,
    input  logic [N_REQ-1:0]    req_lock,
    input  logic [N_REQ*AW-1:0] req_addr,
    input  logic [N_REQ*DW-1:0] req_wdata,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                ram_ena,
    output logic                ram_wea,
    output logic [AW-1:0]       ram_addra,
    output logic [DW-1:0]       ram_dina,
    input  logic [DW-1:0]       ram_douta
);

    localparam int         IW         = idx_width(N_REQ);
    localparam logic [7:0] c_lock_max = 8'(LOCK_MAX);
    localparam bit         c_lock_en  = (LOCK_MAX > 1);

    arb_state_e       r_state;
    logic [IW-1:0]    r_lock_owner;
    logic [7:0]       r_lock_cnt;
    logic [IW-1:0]    r_rd_owner;
    logic             r_rd_pend;

    logic [N_REQ-1:0] w_owner_oh;
    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_start;
    logic [IW-1:0]    w_gidx;
    logic             w_hs;
    logic             w_we;
    logic             w_lock;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]    r_last_grant;
    assign w_start = (r_last_grant == IW'(N_REQ - 1)) ? '0 : r_last_grant + 1'b1;
`else
    assign w_start = '0;
`endif

    // While locked, only the owner is eligible; everyone else stalls.
    assign w_owner_oh = N_REQ'(1) << r_lock_owner;
    assign w_elig     = (r_state == LOCKED) ? (req_valid & w_owner_oh) : req_valid;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .req   (w_elig),
        .start (w_start),
        .grant (w_grant)
    );

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;
    assign ram_ena   = w_hs;
    assign ram_wea   = w_we;

    always_comb begin
        w_gidx    = '0;
        w_we      = 1'b0;
        w_lock    = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx    = IW'(i);
                w_we      = req_we[i];
                w_lock    = req_lock[i];
                ram_addra = req_addr[i*AW +: AW];
                ram_dina  = req_wdata[i*DW +: DW];
            end
        end
    end

    assign rsp_valid = r_rd_pend ? (N_REQ'(1) << r_rd_owner) : '0;
    assign rsp_rdata = ram_douta;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= FREE;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
            r_rd_owner   <= '0;
            r_rd_pend    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= IW'(N_REQ - 1);
`endif
        end else begin
            r_rd_pend <= w_hs & ~w_we;
            if (w_hs) begin
                r_rd_owner <= w_gidx;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (w_hs) begin
                r_last_grant <= w_gidx;
            end
`endif
            case (r_state)
                FREE: begin
                    // The entering handshake is the first grant of the burst.
                    if (w_hs && w_lock && c_lock_en) begin
                        r_state      <= LOCKED;
                        r_lock_owner <= w_gidx;
                        r_lock_cnt   <= 8'd1;
                    end
                end
                LOCKED: begin
                    if (w_hs) begin
                        if (!w_lock || (r_lock_cnt + 8'd1) == c_lock_max) begin
                            r_state    <= FREE;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 8'd1;
                        end
                    end
                end
                default: r_state <= FREE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
//==============================================================================
// Module      : tb_ram_port_arbiter
// Description : Scoreboard bench for ram_port_arbiter with a behavioural RAM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int N        = 2;
    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int LOCK_MAX = 4;

    logic              clka = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_we, req_lock, req_ready, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, ram_dina, ram_douta;
    logic              ram_ena, ram_wea;
    logic [AW-1:0]     ram_addra;

    ram_port_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clka      (clka),      .rst_n     (rst_n),
        .req_valid (req_valid), .req_we    (req_we),
        .req_lock  (req_lock),  .req_addr  (req_addr),
        .req_wdata (req_wdata), .req_ready (req_ready),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata),
        .ram_ena   (ram_ena),   .ram_wea   (ram_wea),
        .ram_addra (ram_addra), .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    always #5 clka = ~clka;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a * 257) ^ 16'h5A5A;
    endfunction

    // Behavioural single-port RAM with registered read data.
    logic [DW-1:0] mem [256];
    initial for (int a = 0; a < 256; a++) mem[a] = init_val(a);
    always @(posedge clka) begin
        if (ram_ena) begin
            if (ram_wea) mem[ram_addra] <= ram_dina;
            else         ram_douta <= mem[ram_addra];
        end
    end

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: memory contents plus lock/priority bookkeeping.
    typedef struct { int req; logic [DW-1:0] data; int due; } rsp_t;
    rsp_t          q[$];
    logic [DW-1:0] shadow [256];
    int            holder, used, last, last_g;

    task automatic model_reset();
        holder = -1;
        used   = 0;
        last   = N - 1;
        q.delete();
    endtask

    function automatic int pick(input logic [N-1:0] v);
        if (holder >= 0) return v[holder] ? holder : -1;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int c = (last + k) % N;
            if (v[c]) return c;
        end
`else
        for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
        return -1;
    endfunction

    task automatic model_grant(input int g, input logic lk);
        last = g;
        if (holder < 0) begin
            if (lk && LOCK_MAX > 1) begin
                holder = g;
                used   = 1;
            end
        end else begin
            used++;
            if (!lk || used >= LOCK_MAX) holder = -1;
        end
    endtask

    // Stimulus state per requester.
    logic [N-1:0]  dv, dwe, dlk;
    logic [AW-1:0] dad [N];
    logic [DW-1:0] dwd [N];

    task automatic pack();
        req_valid = dv;
        req_we    = dwe;
        req_lock  = dlk;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = dad[i];
            req_wdata[i*DW +: DW] = dwd[i];
        end
    endtask

    task automatic eval_cycle();
        int g;
        pack();
        #1;
        g = pick(dv);
        last_g = g;
        chk("req_ready", req_ready, (g >= 0) ? (N'(1) << g) : N'(0));
        chk("ram_ena", ram_ena, g >= 0);
        if (g >= 0) begin
            chk("ram_wea", ram_wea, dwe[g]);
            chk("ram_addra", ram_addra, dad[g]);
            chk("ram_dina", ram_dina, dwd[g]);
            if (dwe[g]) shadow[dad[g]] = dwd[g];
            else        q.push_back('{g, shadow[dad[g]], cyc + 1});
            model_grant(g, dlk[g]);
        end else begin
            chk("ram_idle_drive", {ram_wea, ram_addra, ram_dina}, '0);
        end
    endtask

    task automatic run_cycle();
        eval_cycle();
        @(negedge clka);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dv = '0; dwe = '0; dlk = '0;
        pack();
        model_reset();
        repeat (2) @(negedge clka);
        #1;
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_ram_ena", ram_ena, 1'b0);
        rst_n = 1'b1;
        @(negedge clka);
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    rsp_t mon_e;
    initial begin
        forever begin
            @(negedge clka);
            #2;
            if (rst_n === 1'b1) begin
                if (rsp_valid !== '0) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected actual=%b required=none", rsp_valid);
                    end else begin
                        mon_e = q.pop_front();
                        chk("rsp_cycle", cyc, mon_e.due);
                        chk("rsp_valid", rsp_valid, N'(1) << mon_e.req);
                        chk("rsp_rdata", rsp_rdata, mon_e.data);
                    end
                end else if (q.size() > 0 && q[0].due <= cyc) begin
                    mon_e = q.pop_front();
                    chk("rsp_missing", rsp_valid, N'(1) << mon_e.req);
                end
            end
        end
    end

    initial begin
        for (int a = 0; a < 256; a++) shadow[a] = init_val(a);
        for (int i = 0; i < N; i++) begin
            dad[i] = '0;
            dwd[i] = '0;
        end
        rst_n = 1'b0;
        dv = '0; dwe = '0; dlk = '0;
        pack();
        model_reset();
        repeat (3) @(negedge clka);
        #1;
        chk("reset_ready", req_ready, '0);
        chk("reset_rsp", rsp_valid, '0);
        chk("reset_ram", {ram_ena, ram_wea, ram_addra, ram_dina}, '0);
        rst_n = 1'b1;
        @(negedge clka);

        // Idle: nothing requested, nothing granted, nothing returned.
        repeat (4) begin
            run_cycle();
            chk("idle_rsp", rsp_valid, '0);
        end

        // Write 0xA5 to addr 5 from req0, read it back through req1.
        dv = 2'b01; dwe = 2'b01; dad[0] = 8'd5; dwd[0] = 16'h00A5;
        run_cycle();
        dv = 2'b10; dwe = 2'b00; dad[1] = 8'd5;
        run_cycle();
        dv = 2'b00;
        repeat (2) run_cycle();

        // Both requesters streaming reads.
        dv = 2'b11; dwe = 2'b00; dad[0] = 8'd9; dad[1] = 8'd10;
        repeat (6) run_cycle();
        dv = 2'b00;
        run_cycle();

        // req0 bursts under lock while req1 waits.
        do_reset();
        dv = 2'b11; dwe = 2'b00; dlk = 2'b01; dad[0] = 8'd20; dad[1] = 8'd21;
        repeat (8) run_cycle();
        dv = 2'b00; dlk = 2'b00;
        run_cycle();

        // Locked owner goes idle; req1 must stay stalled until the release.
        do_reset();
        dv = 2'b11; dlk = 2'b01;
        run_cycle();
        dv = 2'b10;
        repeat (3) run_cycle();
        dv = 2'b11; dlk = 2'b00;
        run_cycle();
        dv = 2'b10;
        run_cycle();
        dv = 2'b00;
        run_cycle();

        // Reset right after a locked read handshake drops the response.
        do_reset();
        dv = 2'b01; dlk = 2'b01; dwe = 2'b00; dad[0] = 8'd5;
        eval_cycle();
        @(posedge clka);
        #1;
        rst_n = 1'b0;
        model_reset();
        dv = 2'b00; dlk = 2'b00;
        pack();
        #1;
        chk("midrst_rsp", rsp_valid, '0);
        @(negedge clka);
        chk("midrst_rsp_hold", rsp_valid, '0);
        @(negedge clka);
        rst_n = 1'b1;
        dv = 2'b10; dad[1] = 8'd3;
        run_cycle();
        dv = 2'b00;
        repeat (2) run_cycle();

        // Randomized traffic; requests hold until granted.
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                if (!dv[i] && $urandom_range(0, 2) != 0) begin
                    dv[i]  = 1'b1;
                    dwe[i] = 1'($urandom_range(0, 1));
                    dlk[i] = ($urandom_range(0, 3) == 0);
                    dad[i] = AW'($urandom_range(0, 15));
                    dwd[i] = DW'($urandom);
                end
            end
            run_cycle();
            if (last_g >= 0) dv[last_g] = 1'b0;
        end
        dv = '0;
        repeat (3) run_cycle();
        chk("scoreboard_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
